// File: rtl/pmod_button_conditioner_pkg.sv
// Shared constants and types for the PMOD button conditioner.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pmod_button_conditioner_pkg;

  // Debounce timing shared with the board top and the firmware header.
  localparam int PMODBTN_TICKDIV = 1000;
  localparam int PMODBTN_DBTICKS = 20;

  // Firmware-visible bit map of the SoC ports.
  localparam int IPORT_STABLE_LSB   = 0;
  localparam int IPORT_PRESS_LSB    = 4;
  localparam int IPORT_REL_LSB      = 8;
  localparam int OPORT_CLR_MASK_LSB = 8;

  // Per-channel status bundle produced by one debounce cell.
  typedef struct packed {
    logic stable;
    logic press;
    logic rel;
    logic edge_pulse;
  } btn_status_t;

  // Width of a counter that must reach dbticks.
  function automatic int cnt_width(input int dbticks);
    return (dbticks < 1) ? 1 : $clog2(dbticks + 1);
  endfunction

endpackage

// File: rtl/button_debounce_cell.sv
// One button channel: 2-flop sync, tick-based debounce, sticky press/release flags, edge pulse.
// Latency: 2 sync cycles plus DBTICKS ticks from raw change to stable update.
// Backpressure: none; clear is write-1-to-clear and loses to a simultaneous set.
module button_debounce_cell
  import pmod_button_conditioner_pkg::*;
#(
  parameter int DBTICKS = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_raw,
  input  logic        tick,
  input  logic        clr,
  output btn_status_t status
);

  localparam int CW = cnt_width(DBTICKS);

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic          edge_q;
  logic          press;
  logic          rel;
  logic [CW-1:0] cnt;
  logic          accept;

  // A differing level is accepted on the tick that completes the DBTICKS-th differing tick.
  assign accept = (sync2 != stable) && tick && (cnt == CW'(DBTICKS - 1));

  // Two-flop synchronizer for the asynchronous button level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // Debounce counter; any return to equality discards the partial count.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      stable <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      edge_q <= 1'b0;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (accept) begin
        stable <= sync2;
        cnt    <= '0;
        edge_q <= 1'b1;
      end else if (tick) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Sticky flags: set wins over a same-cycle clear so no event is lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      press <= 1'b0;
      rel   <= 1'b0;
    end else begin
      press <= (press & ~clr) | (accept & sync2);
      rel   <= (rel & ~clr) | (accept & ~sync2);
    end
  end

  assign status = '{stable: stable, press: press, rel: rel, edge_pulse: edge_q};

endmodule

// File: rtl/pmod_button_conditioner.sv
// Conditions raw PMOD button levels: shared tick prescaler, per-channel debounce cells, IRQ.
// Latency: 2 + (DBTICKS-1)*TICKDIV + 1..TICKDIV cycles to stable; IRQ one cycle after flags.
// Backpressure: none; flags are sticky until cleared by CLR_STB/CLR_MASK.
module pmod_button_conditioner
  import pmod_button_conditioner_pkg::*;
#(
  parameter int NBTN    = 4,
  parameter int TICKDIV = PMODBTN_TICKDIV,
  parameter int DBTICKS = PMODBTN_DBTICKS
) (
  input  logic            CLK,
  input  logic            RES,
  input  logic [NBTN-1:0] BTN_RAW,
  input  logic            CLR_STB,
  input  logic [NBTN-1:0] CLR_MASK,
  input  logic [NBTN-1:0] IRQ_EN,
  output logic [NBTN-1:0] BTN_STABLE,
  output logic [NBTN-1:0] BTN_PRESS,
  output logic [NBTN-1:0] BTN_REL,
  output logic [NBTN-1:0] BTN_EDGE,
  output logic            IRQ
);

  localparam int PW = (TICKDIV > 1) ? $clog2(TICKDIV) : 1;

  logic [PW-1:0]   pre_cnt;
  logic            tick;
  logic [NBTN-1:0] clr;
  btn_status_t     st [NBTN];

  assign tick = (pre_cnt == PW'(TICKDIV - 1));
  assign clr  = CLR_STB ? CLR_MASK : '0;

  // Shared prescaler: counts 0..TICKDIV-1, tick on the last count.
  always_ff @(posedge CLK) begin
    if (RES || tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < NBTN; i++) begin : g_cell
    button_debounce_cell #(
      .DBTICKS(DBTICKS)
    ) u_cell (
      .clk    (CLK),
      .rst    (RES),
      .btn_raw(BTN_RAW[i]),
      .tick   (tick),
      .clr    (clr[i]),
      .status (st[i])
    );

    assign BTN_STABLE[i] = st[i].stable;
    assign BTN_PRESS[i]  = st[i].press;
    assign BTN_REL[i]    = st[i].rel;
    assign BTN_EDGE[i]   = st[i].edge_pulse;
  end

  // Interrupt is the registered OR of all enabled sticky flags.
  always_ff @(posedge CLK) begin
    if (RES) begin
      IRQ <= 1'b0;
    end else begin
      IRQ <= |((BTN_PRESS | BTN_REL) & IRQ_EN);
    end
  end

endmodule

// File: tb/tb_pmod_button_conditioner.sv
module tb_pmod_button_conditioner;

  localparam int NB = 4;
  localparam int TD = 4;
  localparam int DB = 3;

  logic          CLK = 1'b0;
  logic          RES = 1'b1;
  logic [NB-1:0] BTN_RAW = '1;
  logic          CLR_STB = 1'b0;
  logic [NB-1:0] CLR_MASK = '0;
  logic [NB-1:0] IRQ_EN = '0;
  logic [NB-1:0] BTN_STABLE, BTN_PRESS, BTN_REL, BTN_EDGE;
  logic          IRQ;

  int nchk = 0;
  int nerr = 0;

  pmod_button_conditioner #(.NBTN(NB), .TICKDIV(TD), .DBTICKS(DB)) dut (
    .CLK(CLK), .RES(RES), .BTN_RAW(BTN_RAW), .CLR_STB(CLR_STB), .CLR_MASK(CLR_MASK),
    .IRQ_EN(IRQ_EN), .BTN_STABLE(BTN_STABLE), .BTN_PRESS(BTN_PRESS), .BTN_REL(BTN_REL),
    .BTN_EDGE(BTN_EDGE), .IRQ(IRQ)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The level seen by the debouncer is the raw level two edges late. Once it
  // starts to differ from the accepted level at edge 'since', acceptance is
  // scheduled arithmetically: the first tick at or after that edge, plus
  // DB-1 further tick periods. Ticks fall on edges where since % TD == TD-1.
  logic [NB-1:0] r1, r2, m_stable, m_press, m_rel, m_edge;
  logic          m_irq;
  int            since;
  bit            act [NB];
  int            acc [NB];
  logic [NB-1:0] s, setp, setr, clrm;

  task automatic model_step();
    if (RES) begin
      r1 = '0; r2 = '0; m_stable = '0; m_press = '0; m_rel = '0; m_edge = '0; m_irq = 1'b0;
      since = 0;
      for (int i = 0; i < NB; i++) act[i] = 1'b0;
    end else begin
      s = r2;
      m_irq = |((m_press | m_rel) & IRQ_EN);
      m_edge = '0; setp = '0; setr = '0;
      for (int i = 0; i < NB; i++) begin
        if (s[i] != m_stable[i]) begin
          if (!act[i]) begin
            act[i] = 1'b1;
            acc[i] = since + (TD - 1 - (since % TD)) + (DB - 1) * TD;
          end
          if (since == acc[i]) begin
            m_stable[i] = s[i];
            m_edge[i] = 1'b1;
            act[i] = 1'b0;
            if (s[i]) setp[i] = 1'b1; else setr[i] = 1'b1;
          end
        end else begin
          act[i] = 1'b0;
        end
      end
      clrm = CLR_STB ? CLR_MASK : '0;
      m_press = (m_press & ~clrm) | setp;
      m_rel   = (m_rel & ~clrm) | setr;
      r2 = r1;
      r1 = BTN_RAW;
      since++;
    end
  endtask

  initial forever begin
    @(posedge CLK);
    model_step();
  end

  // Cycle-by-cycle comparison against the model.
  initial forever begin
    @(posedge CLK);
    #2;
    chk("cyc_stable", BTN_STABLE, m_stable);
    chk("cyc_press", BTN_PRESS, m_press);
    chk("cyc_rel", BTN_REL, m_rel);
    chk("cyc_edge", BTN_EDGE, m_edge);
    chk("cyc_irq", IRQ, m_irq);
  end

  // ---------------- directed stimulus ----------------
  task automatic watch(input int ncyc, input int ch, input logic lvl, output int first, output int edges);
    first = -1;
    edges = 0;
    for (int k = 1; k <= ncyc; k++) begin
      @(posedge CLK); #1;
      if (BTN_EDGE[ch]) edges++;
      if (first < 0 && BTN_STABLE[ch] == lvl) first = k;
    end
  endtask

  task automatic clear(input logic [NB-1:0] m);
    @(negedge CLK);
    CLR_STB = 1'b1; CLR_MASK = m;
    @(negedge CLK);
    CLR_STB = 1'b0; CLR_MASK = '0;
  endtask

  int  f, e;
  bit  hit;

  initial begin
    // 1. reset with all buttons held
    repeat (3) begin
      @(posedge CLK); #1;
      chk("rst_outputs_zero", {BTN_STABLE, BTN_PRESS, BTN_REL, BTN_EDGE, IRQ}, 0);
    end
    @(negedge CLK); RES = 1'b0;
    watch(20, 0, 1'b1, f, e);
    chk("rst_accept_window", (f >= 1 && f <= 14), 1);
    chk("rst_stable_all", BTN_STABLE, 4'hF);
    chk("rst_press_all", BTN_PRESS, 4'hF);
    chk("rst_edge_count", e, 1);
    clear(4'hF);
    chk("rst_press_cleared", BTN_PRESS, 4'h0);
    @(negedge CLK); BTN_RAW = 4'h0;
    watch(20, 0, 1'b0, f, e);
    chk("rel_all_stable", BTN_STABLE, 4'h0);
    chk("rel_all_flag", BTN_REL, 4'hF);
    clear(4'hF);

    // 2. short glitch on channel 0
    @(negedge CLK); BTN_RAW = 4'b0001;
    repeat (5) @(negedge CLK);
    BTN_RAW = 4'b0000;
    watch(20, 0, 1'b1, f, e);
    chk("glitch_no_accept", f, -1);
    chk("glitch_no_edge", e, 0);
    chk("glitch_press", BTN_PRESS, 4'h0);
    chk("glitch_cnt_probe", dut.g_cell[0].u_cell.cnt, 0);

    // 3. clean press and release on channel 1
    @(negedge CLK); BTN_RAW = 4'b0010;
    watch(20, 1, 1'b1, f, e);
    chk("press_latency_11_14", (f >= 11 && f <= 14), 1);
    chk("press_flag", BTN_PRESS, 4'b0010);
    chk("press_edge_count", e, 1);
    @(negedge CLK); BTN_RAW = 4'b0000;
    watch(20, 1, 1'b0, f, e);
    chk("release_latency_11_14", (f >= 11 && f <= 14), 1);
    chk("release_flag", BTN_REL, 4'b0010);
    chk("release_edge_count", e, 1);

    // 4. clear behaviour
    clear(4'b0001);
    chk("clr_other_mask", BTN_PRESS, 4'b0010);
    @(negedge CLK); CLR_MASK = 4'b0010;
    @(negedge CLK); CLR_MASK = 4'b0000;
    chk("clr_no_strobe", BTN_PRESS, 4'b0010);
    clear(4'b0010);
    chk("clr_press", BTN_PRESS, 4'b0000);
    chk("clr_rel", BTN_REL, 4'b0000);

    // 5. clear strobe on the exact acceptance edge of channel 2
    @(negedge CLK); BTN_RAW = 4'b0100;
    hit = 1'b0;
    for (int k = 0; k < 20 && !hit; k++) begin
      @(negedge CLK);
      if (act[2] && acc[2] == since) begin
        chk("coll_pre_stable", BTN_STABLE[2], 0);
        CLR_STB = 1'b1; CLR_MASK = 4'b0100;
        hit = 1'b1;
        @(negedge CLK);
        CLR_STB = 1'b0; CLR_MASK = 4'b0000;
      end
    end
    chk("coll_hit", hit, 1);
    chk("coll_stable", BTN_STABLE[2], 1);
    chk("coll_set_wins", BTN_PRESS[2], 1);

    // 6. interrupt path
    clear(4'hF);
    @(negedge CLK); IRQ_EN = 4'b1000; BTN_RAW = 4'b1100;
    hit = 1'b0;
    for (int k = 0; k < 20 && !hit; k++) begin
      @(posedge CLK); #1;
      if (BTN_PRESS[3]) begin
        hit = 1'b1;
        chk("irq_lags_press", IRQ, 0);
        @(posedge CLK); #1;
        chk("irq_after_press", IRQ, 1);
      end
    end
    chk("irq_press_seen", hit, 1);
    @(negedge CLK); BTN_RAW = 4'b1101;
    watch(20, 0, 1'b1, f, e);
    chk("irq_ch0_press", BTN_PRESS[0], 1);
    chk("irq_ch0_no_effect", IRQ, 1);
    clear(4'b1000);
    chk("irq_clr_press3", BTN_PRESS[3], 0);
    chk("irq_still_one", IRQ, 1);
    @(posedge CLK); #1;
    chk("irq_cleared", IRQ, 0);

    repeat (3) @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
